// File: rtl/stream_burst_arbiter_if.sv
// Stream bundle between the HOG descriptor producers, the burst arbiter and the
// external-bus stream input. The arbiter takes the master view.
interface stream_burst_arbiter_if #(
  parameter int DATA_WIDTH   = 128,
  parameter int NUM_SRC      = 2,
  parameter int SRC_ID_WIDTH = 1
);
  logic [NUM_SRC*DATA_WIDTH-1:0] src_data;
  logic [NUM_SRC-1:0]            src_valid;
  logic [NUM_SRC-1:0]            src_ready;
  logic [DATA_WIDTH-1:0]         out_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [SRC_ID_WIDTH-1:0]       out_src_id;
  logic                          grant_active;
  logic                          burst_done;

  modport master (
    input  src_data, src_valid, out_ready,
    output src_ready, out_data, out_valid, out_src_id, grant_active, burst_done
  );

  modport slave (
    output src_data, src_valid, out_ready,
    input  src_ready, out_data, out_valid, out_src_id, grant_active, burst_done
  );
endinterface

// File: rtl/stream_burst_arbiter.sv
// Round-robin burst arbiter: grants one producer at a time for BURST_LEN beats and
// passes its stream through combinationally, tagging the burst with the source ID.
module stream_burst_arbiter #(
  parameter int DATA_WIDTH   = 128,
  parameter int NUM_SRC      = 2,
  parameter int SRC_ID_WIDTH = 1,
  parameter int BURST_LEN    = 4,
  parameter int CNT_WIDTH    = 2
) (
  input logic                    clk,
  input logic                    rst,
  stream_burst_arbiter_if.master bus
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                  state;
  logic [SRC_ID_WIDTH-1:0] grant;
  logic [SRC_ID_WIDTH-1:0] rr_ptr;
  logic [CNT_WIDTH-1:0]    beat_cnt;
  logic                    burst_done_q;

  logic [SRC_ID_WIDTH-1:0] pick;
  logic                    pick_valid;
  logic [DATA_WIDTH-1:0]   mux_data;
  logic                    mux_valid;
  logic                    beat;
  logic                    last_beat;

  // First requester at or after rr_ptr, wrapping modulo NUM_SRC.
  always_comb begin
    logic [SRC_ID_WIDTH-1:0] cand;
    pick_valid = 1'b0;
    pick       = rr_ptr;
    cand       = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = SRC_ID_WIDTH'((int'(rr_ptr) + k) % NUM_SRC);
      if (!pick_valid && bus.src_valid[cand]) begin
        pick_valid = 1'b1;
        pick       = cand;
      end
    end
  end

  always_comb begin
    mux_data  = '0;
    mux_valid = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant == SRC_ID_WIDTH'(i)) begin
        mux_data  = bus.src_data[i*DATA_WIDTH +: DATA_WIDTH];
        mux_valid = bus.src_valid[i];
      end
    end
  end

  // Zero-latency pass-through; everything is blocked outside a burst.
  always_comb begin
    bus.out_data  = '0;
    bus.out_valid = 1'b0;
    bus.src_ready = '0;
    if (state == BURST) begin
      bus.out_data         = mux_data;
      bus.out_valid        = mux_valid;
      bus.src_ready[grant] = bus.out_ready;
    end
  end

  assign beat      = (state == BURST) && mux_valid && bus.out_ready;
  assign last_beat = (beat_cnt == CNT_WIDTH'(BURST_LEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      grant        <= '0;
      rr_ptr       <= '0;
      beat_cnt     <= '0;
      burst_done_q <= 1'b0;
    end else begin
      burst_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant    <= pick;
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          // A stalled source keeps the grant; there is no timeout or preemption.
          if (beat) begin
            if (last_beat) begin
              state        <= IDLE;
              beat_cnt     <= '0;
              burst_done_q <= 1'b1;
              rr_ptr       <= (grant == SRC_ID_WIDTH'(NUM_SRC - 1)) ? '0
                                                                     : grant + SRC_ID_WIDTH'(1);
            end else begin
              beat_cnt <= beat_cnt + CNT_WIDTH'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_src_id   = grant;
  assign bus.grant_active = (state == BURST);
  assign bus.burst_done   = burst_done_q;

endmodule

// File: tb/tb_stream_burst_arbiter.sv
// Bench for stream_burst_arbiter: vector table, directed corner sequences and a
// randomized run checked against a burst-level reference model.
module tb_stream_burst_arbiter;
  localparam int DW = 128;
  localparam int NS = 2;
  localparam int IW = 1;
  localparam int BL = 4;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stream_burst_arbiter_if #(.DATA_WIDTH(DW), .NUM_SRC(NS), .SRC_ID_WIDTH(IW)) bus ();

  stream_burst_arbiter #(
    .DATA_WIDTH(DW), .NUM_SRC(NS), .SRC_ID_WIDTH(IW), .BURST_LEN(BL), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int hs_cnt[NS];

  // Reference model: who owns the bus, beats still owed, where the next search starts.
  bit m_busy;
  int m_owner;
  int m_left;
  int m_next;
  bit m_done;

  typedef struct {
    logic          r;
    logic [NS-1:0] v;
    logic          rdy;
    logic          ga;
    int            id;
    logic          ov;
    logic [NS-1:0] sr;
    logic          bd;
  } vec_t;

  vec_t vecs[15];

  function automatic logic [DW-1:0] make_data(int src, int seq);
    return {32'(src + 1), 32'(seq), 32'(seq * 7 + src), 32'hC0DE_0000 | 32'(src)};
  endfunction

  task automatic modelReset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_left  = 0;
    m_next  = 0;
    m_done  = 1'b0;
  endtask

  task automatic refreshData();
    for (int i = 0; i < NS; i++) bus.src_data[i*DW +: DW] = make_data(i, hs_cnt[i]);
  endtask

  task automatic applyStimulus(input logic r, input logic [NS-1:0] v, input logic rdy);
    rst           = r;
    bus.src_valid = v;
    bus.out_ready = rdy;
    if (r) modelReset();
    refreshData();
  endtask

  task automatic checkVal(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    logic          ov;
    logic [NS-1:0] sr;
    ov = m_busy && bus.src_valid[m_owner];
    sr = (m_busy && bus.out_ready) ? (NS'(1) << m_owner) : '0;
    checkVal("grant_active", bus.grant_active, m_busy);
    checkVal("out_src_id", bus.out_src_id, m_owner);
    checkVal("burst_done", bus.burst_done, m_done);
    checkVal("out_valid", bus.out_valid, ov);
    checkVal("src_ready", bus.src_ready, sr);
    if (ov) checkVal("out_data", bus.out_data, make_data(m_owner, hs_cnt[m_owner]));
  endtask

  task automatic modelStep();
    int  c;
    if (rst) begin
      modelReset();
      return;
    end
    m_done = 1'b0;
    if (m_busy) begin
      if (bus.src_valid[m_owner] && bus.out_ready) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_next = (m_owner + 1) % NS;
          m_done = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < NS; k++) begin
        c = (m_next + k) % NS;
        if (!m_busy && bus.src_valid[c]) begin
          m_busy  = 1'b1;
          m_owner = c;
          m_left  = BL;
        end
      end
    end
  endtask

  // One clock: check mid-cycle, then advance model and producers after the edge.
  task automatic tick();
    logic [NS-1:0] hs;
    @(negedge clk);
    checkOutput();
    hs = bus.src_valid & bus.src_ready;
    @(posedge clk);
    #1;
    modelStep();
    for (int i = 0; i < NS; i++) if (hs[i]) hs_cnt[i]++;
    refreshData();
  endtask

  task automatic resetDut();
    applyStimulus(1'b1, '0, 1'b1);
    tick();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int ids[$];
    int base0, base1, base1b, busy_cycles;
    bit prev_ga;

    for (int i = 0; i < NS; i++) hs_cnt[i] = 0;
    modelReset();

    vecs[0]  = '{1'b1, 2'b01, 1'b1, 1'b0, 0, 1'b0, 2'b00, 1'b0};
    vecs[1]  = '{1'b0, 2'b01, 1'b1, 1'b0, 0, 1'b0, 2'b00, 1'b0};
    vecs[2]  = '{1'b0, 2'b01, 1'b1, 1'b1, 0, 1'b1, 2'b01, 1'b0};
    vecs[3]  = '{1'b0, 2'b01, 1'b1, 1'b1, 0, 1'b1, 2'b01, 1'b0};
    vecs[4]  = '{1'b0, 2'b01, 1'b1, 1'b1, 0, 1'b1, 2'b01, 1'b0};
    vecs[5]  = '{1'b0, 2'b01, 1'b1, 1'b1, 0, 1'b1, 2'b01, 1'b0};
    vecs[6]  = '{1'b0, 2'b00, 1'b1, 1'b0, 0, 1'b0, 2'b00, 1'b1};
    vecs[7]  = '{1'b0, 2'b11, 1'b1, 1'b0, 0, 1'b0, 2'b00, 1'b0};
    vecs[8]  = '{1'b0, 2'b11, 1'b1, 1'b1, 1, 1'b1, 2'b10, 1'b0};
    vecs[9]  = '{1'b0, 2'b11, 1'b0, 1'b1, 1, 1'b1, 2'b00, 1'b0};
    vecs[10] = '{1'b0, 2'b11, 1'b1, 1'b1, 1, 1'b1, 2'b10, 1'b0};
    vecs[11] = '{1'b0, 2'b11, 1'b1, 1'b1, 1, 1'b1, 2'b10, 1'b0};
    vecs[12] = '{1'b0, 2'b11, 1'b1, 1'b1, 1, 1'b1, 2'b10, 1'b0};
    vecs[13] = '{1'b0, 2'b00, 1'b1, 1'b0, 1, 1'b0, 2'b00, 1'b1};
    vecs[14] = '{1'b0, 2'b00, 1'b1, 1'b0, 1, 1'b0, 2'b00, 1'b0};

    $display("[TB] vector table");
    for (int n = 0; n < 15; n++) begin
      applyStimulus(vecs[n].r, vecs[n].v, vecs[n].rdy);
      #1;
      checkVal($sformatf("v%0d_grant_active", n), bus.grant_active, vecs[n].ga);
      checkVal($sformatf("v%0d_out_src_id", n), bus.out_src_id, vecs[n].id);
      checkVal($sformatf("v%0d_out_valid", n), bus.out_valid, vecs[n].ov);
      checkVal($sformatf("v%0d_src_ready", n), bus.src_ready, vecs[n].sr);
      checkVal($sformatf("v%0d_burst_done", n), bus.burst_done, vecs[n].bd);
      tick();
    end

    $display("[TB] alternating bursts");
    resetDut();
    applyStimulus(1'b0, 2'b11, 1'b1);
    base0   = hs_cnt[0];
    base1   = hs_cnt[1];
    prev_ga = 1'b0;
    for (int c = 0; c < 21; c++) begin
      #1;
      if (bus.grant_active && !prev_ga) ids.push_back(int'(bus.out_src_id));
      prev_ga = bus.grant_active;
      tick();
    end
    checkVal("rr_burst_count", ids.size(), 4);
    for (int k = 0; k < ids.size() && k < 4; k++) checkVal($sformatf("rr_id%0d", k), ids[k], k % 2);
    checkVal("rr_beats_src0", hs_cnt[0] - base0, 8);
    checkVal("rr_beats_src1", hs_cnt[1] - base1, 8);

    $display("[TB] mid-burst stall");
    resetDut();
    applyStimulus(1'b0, 2'b01, 1'b1);
    base0 = hs_cnt[0];
    tick();
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b0, 2'b10, 1'b1);
      #1;
      checkVal("stall_grant_active", bus.grant_active, 1'b1);
      checkVal("stall_src_id", bus.out_src_id, 0);
      checkVal("stall_src1_ready", bus.src_ready[1], 1'b0);
      tick();
    end
    applyStimulus(1'b0, 2'b11, 1'b1);
    tick();
    tick();
    #1;
    checkVal("stall_beats", hs_cnt[0] - base0, 4);
    checkVal("stall_done", bus.burst_done, 1'b1);

    $display("[TB] ready toggling");
    resetDut();
    applyStimulus(1'b0, 2'b01, 1'b0);
    base0 = hs_cnt[0];
    tick();
    busy_cycles = 0;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b0, 2'b01, logic'(c % 2));
      #1;
      checkVal($sformatf("toggle_data%0d", c), bus.out_data, make_data(0, base0 + c / 2));
      if (bus.grant_active) busy_cycles++;
      tick();
    end
    #1;
    checkVal("toggle_cycles", busy_cycles, 8);
    checkVal("toggle_beats", hs_cnt[0] - base0, 4);
    checkVal("toggle_idle", bus.grant_active, 1'b0);

    $display("[TB] reset mid-burst");
    resetDut();
    applyStimulus(1'b0, 2'b10, 1'b1);
    base1 = hs_cnt[1];
    tick();
    tick();
    applyStimulus(1'b1, 2'b10, 1'b1);
    #1;
    checkVal("rst_grant_active", bus.grant_active, 1'b0);
    checkVal("rst_out_valid", bus.out_valid, 1'b0);
    checkVal("rst_src_ready", bus.src_ready, 2'b00);
    tick();
    applyStimulus(1'b0, 2'b10, 1'b1);
    base1b = hs_cnt[1];
    checkVal("rst_partial_beats", base1b - base1, 1);
    for (int c = 0; c < 5; c++) tick();
    #1;
    checkVal("rst_resend_beats", hs_cnt[1] - base1b, 4);
    checkVal("rst_resend_done", bus.burst_done, 1'b1);

    $display("[TB] lone requester skip");
    resetDut();
    applyStimulus(1'b0, 2'b10, 1'b1);
    tick();
    #1;
    checkVal("skip_grant_active", bus.grant_active, 1'b1);
    checkVal("skip_src_id", bus.out_src_id, 1);
    for (int c = 0; c < 4; c++) tick();
    #1;
    checkVal("skip_bubble", bus.grant_active, 1'b0);
    tick();
    #1;
    checkVal("skip_regrant", bus.grant_active, 1'b1);
    checkVal("skip_regrant_id", bus.out_src_id, 1);
    tick();

    $display("[TB] randomized run");
    resetDut();
    for (int c = 0; c < 400; c++) begin
      applyStimulus(logic'($urandom_range(0, 63) == 0), NS'($urandom), logic'($urandom_range(0, 3) != 0));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
